// File: rtl/data_mem_bytewise_if.sv
`timescale 1ns/1ps
// data_mem_bytewise_if: load/store port bundle for data_mem_bytewise.
// The master issues the write/read requests; the slave returns load data and errors.
interface data_mem_bytewise_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               we;
  logic [A_WIDTH-1:0] w_addr;
  logic [D_WIDTH-1:0] w_data;
  logic [1:0]         w_size;
  logic               re;
  logic [A_WIDTH-1:0] r_addr;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;
  logic               misalign_err;

  modport master (
    output we, w_addr, w_data, w_size,
    output re, r_addr, r_size, r_signed,
    input  r_data, r_valid, misalign_err
  );

  modport slave (
    input  we, w_addr, w_data, w_size,
    input  re, r_addr, r_size, r_signed,
    output r_data, r_valid, misalign_err
  );
endinterface

// File: rtl/data_mem_bytewise.sv
`timescale 1ns/1ps
// data_mem_bytewise: byte-lane simple-dual-port data RAM with write-through and RD_LAT of 1/2.
// Define DMEM_RANGE_CHECK_EN to flag accesses with non-zero address bits above the row index.
module data_mem_bytewise #(
  parameter int MEM_A_WIDTH = 8,
  parameter int D_WIDTH     = 32,
  parameter int A_WIDTH     = 32,
  parameter int RD_LAT      = 1
) (
  input  logic clk,
  input  logic rst,
  data_mem_bytewise_if.slave bus
);
  localparam int NB   = D_WIDTH / 8;
  localparam int OFF  = $clog2(NB);
  localparam int ROWS = 1 << MEM_A_WIDTH;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef logic [MEM_A_WIDTH-1:0] idx_t;
  typedef logic [OFF-1:0]         off_t;
  typedef logic [NB-1:0]          strb_t;
  typedef logic [D_WIDTH-1:0]     data_t;

  function automatic logic legal(
    input logic [A_WIDTH-1:0] a,
    input logic [1:0]         sz
  );
    logic ok;
    ok = (int'(sz) <= OFF);
    for (int b = 0; b < OFF; b++)
      if (b < int'(sz) && a[b]) ok = 1'b0;
    if (RANGE_EN && ((a >> (MEM_A_WIDTH + OFF)) != '0))
      ok = 1'b0;
    return ok;
  endfunction

  function automatic strb_t strobes(
    input off_t       off,
    input logic [1:0] sz
  );
    strb_t s;
    for (int b = 0; b < NB; b++)
      s[b] = (b >= int'(off)) && (b < int'(off) + (1 << sz));
    return s;
  endfunction

  function automatic data_t extract(
    input data_t      row,
    input off_t       off,
    input logic [1:0] sz,
    input logic       sgn
  );
    data_t sh;
    data_t r;
    int    nb;
    sh = row >> {off, 3'b000};
    nb = 8 << sz;
    if (nb > D_WIDTH) nb = D_WIDTH;
    for (int i = 0; i < D_WIDTH; i++)
      r[i] = (i < nb) ? sh[i] : (sgn & sh[nb-1]);
    return r;
  endfunction

  data_t mem_q [ROWS];

  idx_t  w_idx;
  idx_t  r_idx;
  off_t  w_off;
  off_t  r_off;
  logic  w_ok;
  logic  w_err;
  logic  r_ok;
  strb_t w_strb;
  data_t w_sh;
  data_t row;
  data_t rd_val;

  always_comb begin
    w_idx  = bus.w_addr[MEM_A_WIDTH+OFF-1:OFF];
    r_idx  = bus.r_addr[MEM_A_WIDTH+OFF-1:OFF];
    w_off  = bus.w_addr[OFF-1:0];
    r_off  = bus.r_addr[OFF-1:0];
    w_ok   = bus.we && legal(bus.w_addr, bus.w_size);
    w_err  = bus.we && !w_ok;
    r_ok   = legal(bus.r_addr, bus.r_size);
    w_strb = strobes(w_off, bus.w_size);
    w_sh   = bus.w_data << {w_off, 3'b000};
    row    = mem_q[r_idx];
    // Same-row write in this cycle: the load sees the freshly written lanes
    if (w_ok && bus.re && (w_idx == r_idx)) begin
      for (int b = 0; b < NB; b++)
        if (w_strb[b]) row[8*b +: 8] = w_sh[8*b +: 8];
    end
    rd_val = r_ok ? extract(row, r_off, bus.r_size, bus.r_signed) : '0;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (w_ok && w_strb[b])
        mem_q[w_idx][8*b +: 8] <= w_sh[8*b +: 8];
  end

  logic  werr_q;
  logic  v1_q;
  logic  e1_q;
  data_t d1_q;
  data_t d1_d;

  always_comb begin
    d1_d = d1_q;
    if (bus.re) d1_d = rd_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      werr_q <= 1'b0;
      v1_q   <= 1'b0;
      e1_q   <= 1'b0;
      d1_q   <= '0;
    end else begin
      werr_q <= w_err;
      v1_q   <= bus.re;
      e1_q   <= bus.re && !r_ok;
      d1_q   <= d1_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic  v2_q;
    logic  e2_q;
    data_t d2_q;
    data_t d2_d;

    always_comb begin
      d2_d = d2_q;
      if (v1_q) d2_d = d1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q <= 1'b0;
        e2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        e2_q <= e1_q;
        d2_q <= d2_d;
      end
    end

    // Write error stays one cycle after its request, so it splits from the read error
    assign bus.r_valid      = v2_q;
    assign bus.r_data       = d2_q;
    assign bus.misalign_err = werr_q | e2_q;
  end else begin : g_lat1
    assign bus.r_valid      = v1_q;
    assign bus.r_data       = d1_q;
    assign bus.misalign_err = werr_q | e1_q;
  end
endmodule

// File: tb/tb_data_mem_bytewise.sv
`timescale 1ns/1ps
// Scoreboard bench: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream
// and are checked against a byte-array model of the memory.
module tb_data_mem_bytewise;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MAW    = 8;
  localparam int MBYTES = (1 << MAW) * 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_bytewise_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus1 ();
  data_mem_bytewise_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus2 ();

  data_mem_bytewise #(
    .MEM_A_WIDTH(MAW), .D_WIDTH(DW), .A_WIDTH(AW), .RD_LAT(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  data_mem_bytewise #(
    .MEM_A_WIDTH(MAW), .D_WIDTH(DW), .A_WIDTH(AW), .RD_LAT(2)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic [7:0]  bm [MBYTES];
  exp_t        q [2][$];
  bit          eerr [2][4096];
  logic [31:0] last [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          use_dir = 1'b0;
  logic [31:0] dir_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit m_legal(input logic [31:0] a, input logic [1:0] s);
    if (s > 2'd2) return 1'b0;
    if ((a % (32'd1 << s)) != 0) return 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    if (a >= MBYTES) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(
    input logic [31:0] a, input logic [1:0] s, input logic sg
  );
    int          n;
    logic [31:0] v;
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bm[(a + i) % MBYTES];
    if (sg && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic drive(
    input logic we, input logic [31:0] wa, input logic [31:0] wd,
    input logic [1:0] ws, input logic re, input logic [31:0] ra,
    input logic [1:0] rs, input logic sg
  );
    bus1.we = we; bus1.w_addr = wa; bus1.w_data = wd; bus1.w_size = ws;
    bus1.re = re; bus1.r_addr = ra; bus1.r_size = rs; bus1.r_signed = sg;
    bus2.we = we; bus2.w_addr = wa; bus2.w_data = wd; bus2.w_size = ws;
    bus2.re = re; bus2.r_addr = ra; bus2.r_size = rs; bus2.r_signed = sg;
  endtask

  task automatic step(
    input logic we, input logic [31:0] wa, input logic [31:0] wd,
    input logic [1:0] ws, input logic re, input logic [31:0] ra,
    input logic [1:0] rs, input logic sg
  );
    bit          ok;
    logic [31:0] d;
    @(posedge clk); #1;
    drive(we, wa, wd, ws, re, ra, rs, sg);
    if (we) begin
      if (m_legal(wa, ws)) begin
        for (int i = 0; i < (1 << ws); i++) bm[(wa + i) % MBYTES] = wd[8*i +: 8];
      end else begin
        eerr[0][(cyc + 1) % 4096] = 1'b1;
        eerr[1][(cyc + 1) % 4096] = 1'b1;
      end
    end
    if (re) begin
      ok = m_legal(ra, rs);
      d  = ok ? m_read(ra, rs, sg) : 32'd0;
      if (use_dir) d = dir_val;
      for (int id = 0; id < 2; id++) begin
        q[id].push_back('{data: d, cyc: cyc + id + 1});
        if (!ok) eerr[id][(cyc + id + 1) % 4096] = 1'b1;
      end
    end
    use_dir = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [1:0] s,
                        input logic sg, input logic [31:0] e);
    use_dir = 1'b1;
    dir_val = e;
    step(0, 0, 0, 0, 1, a, s, sg);
  endtask

  task automatic flush_model();
    q[0].delete();
    q[1].delete();
    for (int i = 0; i < 4096; i++) begin
      eerr[0][i] = 1'b0;
      eerr[1][i] = 1'b0;
    end
    last[0] = '0;
    last[1] = '0;
  endtask

  task automatic chk(input int id, input logic rv, input logic [31:0] rd,
                     input logic me);
    bit   ee;
    exp_t e;
    ee = eerr[id][cyc % 4096];
    eerr[id][cyc % 4096] = 1'b0;
    checks++;
    if (me !== ee) begin
      failures++;
      $display("FAIL misalign_err lat%0d cyc=%0d got=%b want=%b", id + 1, cyc, me, ee);
    end
    if (rv === 1'b1) begin
      checks++;
      if (q[id].size() == 0) begin
        failures++;
        $display("FAIL spurious_r_valid lat%0d cyc=%0d data=%h", id + 1, cyc, rd);
      end else begin
        e = q[id].pop_front();
        last[id] = e.data;
        if (e.cyc != cyc || rd !== e.data) begin
          failures++;
          $display("FAIL read lat%0d cyc=%0d got=%h want=%h at_cyc=%0d",
                   id + 1, cyc, rd, e.data, e.cyc);
        end
      end
    end else begin
      checks++;
      if (rv !== 1'b0 || rd !== last[id]) begin
        failures++;
        $display("FAIL idle lat%0d cyc=%0d valid=%b data=%h want_data=%h",
                 id + 1, cyc, rv, rd, last[id]);
      end
      if (q[id].size() > 0 && q[id][0].cyc <= cyc) begin
        checks++;
        failures++;
        e = q[id].pop_front();
        $display("FAIL missing_r_valid lat%0d cyc=%0d want=%h", id + 1, cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    chk(0, bus1.r_valid, bus1.r_data, bus1.misalign_err);
    chk(1, bus2.r_valid, bus2.r_data, bus2.misalign_err);
  end

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom_range(0, 127);
    if ($urandom_range(0, 9) == 0) a = a | ($urandom << 10);
    if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic logic [1:0] rnd_size();
    if ($urandom_range(0, 9) == 0) return 2'd3;
    return 2'($urandom_range(0, 2));
  endfunction

  initial begin
    last[0] = '0;
    last[1] = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 256; i++) step(1, i * 4, $urandom, 2, 0, 0, 0, 0);

    step(1, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 0);
    rd_exp(32'h10, 2, 0, 32'hDEADBEEF);

    step(1, 32'h20, 32'h0, 2, 0, 0, 0, 0);
    step(1, 32'h22, 32'h80, 0, 0, 0, 0, 0);
    rd_exp(32'h22, 0, 1, 32'hFFFFFF80);
    rd_exp(32'h22, 0, 0, 32'h00000080);
    rd_exp(32'h20, 2, 0, 32'h00800000);
    rd_exp(32'h22, 1, 1, 32'h00000080);

    step(1, 32'h40, 32'h11223344, 2, 0, 0, 0, 0);
    use_dir = 1'b1;
    dir_val = 32'hAAAA3344;
    step(1, 32'h42, 32'hAAAA, 1, 1, 32'h40, 2, 0);
    rd_exp(32'h42, 1, 1, 32'hFFFFAAAA);

    step(1, 32'h30, 32'hCAFEF00D, 2, 0, 0, 0, 0);
    step(1, 32'h31, 32'h5555, 1, 0, 0, 0, 0);
    rd_exp(32'h30, 2, 0, 32'hCAFEF00D);
    rd_exp(32'h32, 2, 0, 32'h0);
    step(1, 32'h33, 32'h1234, 1, 1, 32'h31, 1, 0);
    idle(3);

    step(0, 0, 0, 0, 1, 32'h10, 2, 0);
    step(0, 0, 0, 0, 1, 32'h20, 2, 0);
    step(0, 0, 0, 0, 1, 32'h40, 2, 0);
    idle(3);

    step(0, 0, 0, 0, 1, 32'h10, 2, 0);
    step(0, 0, 0, 0, 1, 32'h20, 2, 0);
    step(0, 0, 0, 0, 1, 32'h40, 2, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    step(1, 32'h404, 32'h12345678, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h004, 2, 0);
    step(0, 0, 0, 0, 1, 32'h404, 2, 0);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 1), rnd_addr(), $urandom, rnd_size(),
           $urandom_range(0, 3) != 0, rnd_addr(), rnd_size(), 1'($urandom));
      if (i == 1000) begin
        @(negedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        flush_model();
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    idle(5);

    for (int id = 0; id < 2; id++) begin
      checks++;
      if (q[id].size() != 0) begin
        failures++;
        $display("FAIL drain lat%0d pending=%0d want=0", id + 1, q[id].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
